// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the R-type MIPS sequencer
//
// Purpose: ALU operation selects, opcode/func field values and the
//          sequencer state encoding. Imported by mips_func_decode and
//          mips_r_seq.
// Ports:   none (package)

package mips_pkg;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_NOR  = 3'b011;
    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SLLV = 3'b111;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;

    localparam logic [5:0] FUNC_ADD  = 6'b100000;
    localparam logic [5:0] FUNC_SUB  = 6'b100010;
    localparam logic [5:0] FUNC_AND  = 6'b100100;
    localparam logic [5:0] FUNC_OR   = 6'b100101;
    localparam logic [5:0] FUNC_XOR  = 6'b100110;
    localparam logic [5:0] FUNC_NOR  = 6'b100111;
    localparam logic [5:0] FUNC_SLTU = 6'b101011;
    localparam logic [5:0] FUNC_SLLV = 6'b000100;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

endpackage

// File: rtl/mips_func_decode.sv
// rtl/mips_func_decode.sv - combinational R-type func to ALU operation map
//
// Purpose: translate the 6-bit func field into a 3-bit ALU select and a
//          valid flag; unsupported func codes return valid=0.
// Ports:
//   func    in   6  instruction func field (IR[5:0])
//   valid   out  1  func is one of the supported operations
//   alu_op  out  3  ALU operation select (ALU_AND when not valid)

module mips_func_decode
    import mips_pkg::*;
(
    input  logic [5:0] func,
    output logic       valid,
    output logic [2:0] alu_op
);

    always_comb begin
        valid  = 1'b1;
        alu_op = ALU_AND;
        case (func)
            FUNC_ADD:  alu_op = ALU_ADD;
            FUNC_SUB:  alu_op = ALU_SUB;
            FUNC_AND:  alu_op = ALU_AND;
            FUNC_OR:   alu_op = ALU_OR;
            FUNC_XOR:  alu_op = ALU_XOR;
            FUNC_NOR:  alu_op = ALU_NOR;
            FUNC_SLTU: alu_op = ALU_SLTU;
            FUNC_SLLV: alu_op = ALU_SLLV;
            default:   valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_r_seq.sv
// rtl/mips_r_seq.sv - multi-cycle FETCH/DECODE/EXEC/WB sequencer for R-type MIPS
//
// Purpose: fetch an instruction over a req/ready handshake, decode it into
//          an ALU select and register addresses, and pulse write_reg for
//          one writeback cycle per instruction. Unsupported instructions
//          set a sticky illegal flag and park the sequencer in HALT.
// Ports:
//   clk         in   1      system clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   imem_req    out  1      instruction fetch request (registered)
//   imem_addr   out  32     fetch address, equal to pc
//   imem_ready  in   1      fetch data valid this cycle
//   imem_rdata  in   32     instruction word
//   rs_addr     out  5      read port A address, IR[25:21]
//   rt_addr     out  5      read port B address, IR[20:16]
//   rd_addr     out  5      write address, IR[15:11]
//   alu_op      out  3      ALU operation select (registered, held)
//   write_reg   out  1      register-file write enable (registered)
//   illegal     out  1      sticky unsupported-instruction flag
//   retired     out  CNT_W  count of completed writebacks

module mips_r_seq
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic [4:0]       rs_addr,
    output logic [4:0]       rt_addr,
    output logic [4:0]       rd_addr,
    output logic [2:0]       alu_op,
    output logic             write_reg,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [31:0]      pc, pc_nxt;
    logic [31:0]      ir, ir_nxt;
    logic [2:0]       alu_op_nxt;
    logic             imem_req_nxt;
    logic             write_reg_nxt;
    logic             illegal_nxt;
    logic [CNT_W-1:0] retired_nxt;

    logic             dec_valid;
    logic [2:0]       dec_alu_op;

    mips_func_decode u_func_decode (
        .func   (ir[5:0]),
        .valid  (dec_valid),
        .alu_op (dec_alu_op)
    );

    assign imem_addr = pc;
    assign rs_addr   = ir[25:21];
    assign rt_addr   = ir[20:16];
    assign rd_addr   = ir[15:11];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FETCH;
            pc        <= PC_RESET;
            ir        <= 32'h0000_0000;
            alu_op    <= ALU_AND;
            imem_req  <= 1'b0;
            write_reg <= 1'b0;
            illegal   <= 1'b0;
            retired   <= '0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            ir        <= ir_nxt;
            alu_op    <= alu_op_nxt;
            imem_req  <= imem_req_nxt;
            write_reg <= write_reg_nxt;
            illegal   <= illegal_nxt;
            retired   <= retired_nxt;
        end
    end

    // All outputs are registered, so this block computes the value each
    // output will carry during the next state, not the current one.
    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        ir_nxt        = ir;
        alu_op_nxt    = alu_op;
        imem_req_nxt  = imem_req;
        write_reg_nxt = 1'b0;
        illegal_nxt   = illegal;
        retired_nxt   = retired;

        case (state)
            ST_FETCH: begin
                // After reset imem_req starts low, so the first FETCH cycle
                // only raises the request; afterwards WB pre-raises it.
                if (imem_req && imem_ready) begin
                    ir_nxt       = imem_rdata;
                    pc_nxt       = pc + 32'd4;
                    imem_req_nxt = 1'b0;
                    state_nxt    = ST_DECODE;
                end else begin
                    imem_req_nxt = 1'b1;
                end
            end
            ST_DECODE: begin
                if ((ir[31:26] != OP_RTYPE) || !dec_valid) begin
                    illegal_nxt = 1'b1;
                    state_nxt   = ST_HALT;
                end else begin
                    alu_op_nxt = dec_alu_op;
                    state_nxt  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Writes to $zero are dropped but still retire in WB.
                write_reg_nxt = (ir[15:11] != 5'd0);
                state_nxt     = ST_WB;
            end
            ST_WB: begin
                retired_nxt  = retired + CNT_ONE;
                imem_req_nxt = 1'b1;
                state_nxt    = ST_FETCH;
            end
            ST_HALT: begin
                imem_req_nxt = 1'b0;
                illegal_nxt  = 1'b1;
            end
            default: begin
                imem_req_nxt = 1'b0;
                state_nxt    = ST_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_r_seq.sv
// tb/tb_mips_r_seq.sv - self-checking bench for mips_r_seq

module tb_mips_r_seq;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [2:0]  alu_op;
    logic        write_reg;
    logic        illegal;
    logic [15:0] retired;

    mips_r_seq #(.PC_RESET(32'h0000_0000), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rd_addr    (rd_addr),
        .alu_op     (alu_op),
        .write_reg  (write_reg),
        .illegal    (illegal),
        .retired    (retired)
    );

    typedef struct {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [2:0]  op;
        logic        wr;
        logic [15:0] cnt;
        logic [31:0] npc;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem       [0:15];
    logic [4:0]  mem_rs    [0:15];
    logic [4:0]  mem_rt    [0:15];
    logic [4:0]  mem_rd    [0:15];
    logic [2:0]  mem_op    [0:15];
    int          stall_tab [0:15];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          stall_cnt = 0;
    int          t_exp;
    logic [15:0] cnt_exp;
    int          pulses = 0;
    int          pulses_exp = 0;
    logic [15:0] last_ret = 16'd0;
    logic        prev_wr = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'b00000, fn};
    endfunction

    task automatic load(input int idx, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [5:0] fn, input logic [2:0] op);
        mem[idx]    = rtype(rs, rt, rd, fn);
        mem_rs[idx] = rs;
        mem_rt[idx] = rt;
        mem_rd[idx] = rd;
        mem_op[idx] = op;
    endtask

    // Expected retirement of the instruction at word idx; t_exp is the
    // cycle of the retire sample (one after WB).
    task automatic expect_instr(input int idx);
        exp_t e;
        t_exp   = t_exp + 4 + stall_tab[idx];
        cnt_exp = cnt_exp + 16'd1;
        e.rs  = mem_rs[idx];
        e.rt  = mem_rt[idx];
        e.rd  = mem_rd[idx];
        e.op  = mem_op[idx];
        e.wr  = (mem_rd[idx] != 5'd0);
        e.cnt = cnt_exp;
        e.npc = 32'((idx + 1) * 4);
        e.cyc = t_exp;
        if (e.wr) pulses_exp++;
        exp_q.push_back(e);
    endtask

    // One cycle of instruction-memory behaviour, driven at the falling edge.
    task automatic tick();
        @(negedge clk);
        imem_rdata = mem[imem_addr[5:2]];
        if (imem_req && stall_cnt < stall_tab[imem_addr[5:2]]) begin
            imem_ready = 1'b0;
            stall_cnt++;
        end else begin
            imem_ready = 1'b1;
            if (imem_req) stall_cnt = 0;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_ret = retired;
            prev_wr  = 1'b0;
        end else begin
            if (write_reg) pulses++;
            if (retired !== last_ret) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_retire", {16'd0, retired}, {16'd0, last_ret});
                end else begin
                    e = exp_q.pop_front();
                    check("wb_write_reg", {31'd0, prev_wr}, {31'd0, e.wr});
                    check("wb_rd", {27'd0, rd_addr}, {27'd0, e.rd});
                    check("wb_rs", {27'd0, rs_addr}, {27'd0, e.rs});
                    check("wb_rt", {27'd0, rt_addr}, {27'd0, e.rt});
                    check("wb_alu_op", {29'd0, alu_op}, {29'd0, e.op});
                    check("retired", {16'd0, retired}, {16'd0, e.cnt});
                    check("next_pc", imem_addr, e.npc);
                    check("retire_cycle", 32'(cyc), 32'(e.cyc));
                    check("write_reg_after_wb", {31'd0, write_reg}, 32'd0);
                end
            end
            last_ret = retired;
            prev_wr  = write_reg;
        end
    end

    initial begin
        rst_n      = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        for (int i = 0; i < 16; i++) begin
            mem[i] = 32'h0; mem_rs[i] = 5'd0; mem_rt[i] = 5'd0;
            mem_rd[i] = 5'd0; mem_op[i] = 3'd0; stall_tab[i] = 0;
        end
        load(0, 5'd2, 5'd3, 5'd1, 6'b100000, 3'b100);
        load(1, 5'd3, 5'd4, 5'd2, 6'b100010, 3'b101);
        load(2, 5'd4, 5'd5, 5'd3, 6'b100100, 3'b000);
        load(3, 5'd5, 5'd6, 5'd4, 6'b100101, 3'b001);
        load(4, 5'd6, 5'd7, 5'd5, 6'b100110, 3'b010);
        load(5, 5'd7, 5'd8, 5'd6, 6'b100111, 3'b011);
        load(6, 5'd8, 5'd9, 5'd7, 6'b101011, 3'b110);
        load(7, 5'd9, 5'd10, 5'd8, 6'b000100, 3'b111);
        load(8, 5'd2, 5'd3, 5'd0, 6'b100000, 3'b100);
        load(9, 5'd7, 5'd8, 5'd9, 6'b100010, 3'b101);
        mem[10] = 32'h8C22_0000;
        stall_tab[9] = 5;

        // Reset state
        repeat (3) tick();
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_write_reg", {31'd0, write_reg}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_retired", {16'd0, retired}, 32'd0);
        check("rst_alu_op", {29'd0, alu_op}, 32'd0);
        check("rst_rd_addr", {27'd0, rd_addr}, 32'd0);

        // Eight funcs back to back, rd=0 write, then stalled fetch, then lw
        rst_n   = 1'b1;
        t_exp   = cyc + 1;
        cnt_exp = 16'd0;
        for (int i = 0; i < 10; i++) expect_instr(i);
        tick();
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h0);
        repeat (59) tick();
        check("p1_queue_empty", 32'(exp_q.size()), 32'd0);
        check("halt_illegal", {31'd0, illegal}, 32'd1);
        check("halt_req", {31'd0, imem_req}, 32'd0);
        check("halt_write_reg", {31'd0, write_reg}, 32'd0);
        check("halt_retired", {16'd0, retired}, 32'd10);
        check("halt_pc", imem_addr, 32'h0000_002C);
        check("halt_alu_op", {29'd0, alu_op}, 32'b101);
        check("p1_pulses", 32'(pulses), 32'(pulses_exp));

        // Reset during a stalled fetch at pc=0x8
        #2 rst_n = 1'b0;
        stall_cnt = 0;
        repeat (2) tick();
        check("rst2_illegal", {31'd0, illegal}, 32'd0);
        stall_tab[2] = 40;
        rst_n   = 1'b1;
        t_exp   = cyc + 1;
        cnt_exp = 16'd0;
        expect_instr(0);
        expect_instr(1);
        for (int i = 0; i < 40 && !(imem_req && imem_addr == 32'h8); i++) tick();
        check("stall_req_at_8", {31'd0, imem_req}, 32'd1);
        check("stall_addr_at_8", imem_addr, 32'h8);
        repeat (3) tick();
        check("stall_addr_stable", imem_addr, 32'h8);
        check("stall_no_write", {31'd0, write_reg}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_req_drop", {31'd0, imem_req}, 32'd0);
        check("async_pc", imem_addr, 32'h0);
        check("async_retired", {16'd0, retired}, 32'd0);
        stall_cnt = 0;
        repeat (2) tick();

        // Restart after mid-operation reset
        rst_n   = 1'b1;
        t_exp   = cyc + 1;
        cnt_exp = 16'd0;
        expect_instr(0);
        expect_instr(1);
        tick();
        check("restart_req", {31'd0, imem_req}, 32'd1);
        check("restart_addr", imem_addr, 32'h0);
        repeat (12) tick();
        check("p3_queue_empty", 32'(exp_q.size()), 32'd0);
        check("p3_retired", {16'd0, retired}, 32'd2);
        check("p3_req_at_8", {31'd0, imem_req}, 32'd1);
        check("p3_addr_at_8", imem_addr, 32'h8);
        check("total_pulses", 32'(pulses), 32'(pulses_exp));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
